// File: rtl/acumulador_sat_pkg.sv
// Shared fixed-point filter definitions: default widths and saturation limits.
// No logic, no latency.
// No flow control; constants only.
package acumulador_sat_pkg;

    localparam int W_DEF   = 25;
    localparam int CH_DEF  = 4;
    localparam int CHW_DEF = 2;

    // Largest positive value of a w-bit signed word: 2**(w-1)-1
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Symmetric negative limit: -(2**(w-1)-1); the most negative code is never produced
    function automatic longint sat_min(input int w);
        return -sat_max(w);
    endfunction

endpackage

// File: rtl/sumador_sat_sim.sv
// Combinational W-bit signed adder with optional symmetric saturation and overflow output.
// Latency: 0 cycles (pure combinational).
// No flow control; the result is valid whenever the inputs are.
module sumador_sat_sim
    import acumulador_sat_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sat_en,
    output logic signed [W-1:0] result,
    output logic                ovf
);

    localparam logic signed [W-1:0] MAX      = W'(sat_max(W));
    localparam logic signed [W-1:0] MIN      = W'(sat_min(W));
    localparam logic signed [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W:0] sum;

    // Sign-extended add; overflow is flagged in both modes, clamping only in saturate mode
    always_comb begin
        sum    = {a[W-1], a} + {b[W-1], b};
        ovf    = sum[W] ^ sum[W-1];
        result = sum[W-1:0];
        if (sat_en) begin
            if (ovf) begin
                result = sum[W] ? MIN : MAX;
            end else if (sum[W-1:0] == MOST_NEG) begin
                // Keep the range symmetric: the lone most-negative code folds to MIN
                result = MIN;
            end
        end
    end

endmodule

// File: rtl/acumulador_sat.sv
// Multi-channel signed accumulator with saturate/wrap arithmetic and sticky overflow flags.
// Latency: 2 cycles from sample to result strobe (input register, then accumulate/output register).
// No backpressure: accepts one sample per cycle on any channel, same-channel back-to-back without stall.
module acumulador_sat
    import acumulador_sat_pkg::*;
#(
    parameter int W   = W_DEF,
    parameter int CH  = CH_DEF,
    parameter int CHW = CHW_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    input  logic [CHW-1:0]      in_ch,
    input  logic signed [W-1:0] in_data,
    input  logic                in_clr,
    input  logic                in_last,
    input  logic                sat_en,
    input  logic [CH-1:0]       flag_clr,
    output logic                out_valid,
    output logic [CHW-1:0]      out_ch,
    output logic signed [W-1:0] out_data,
    output logic [CH-1:0]       ovf_flag
);

    localparam logic [CHW:0] CH_LIM = CH[CHW:0];

    logic                in_ok;
    logic                s1_vld;
    logic [CHW-1:0]      s1_ch;
    logic signed [W-1:0] s1_dat;
    logic                s1_clr;
    logic                s1_last;
    logic                s1_sat;

    logic signed [W-1:0] acc [CH];
    logic signed [W-1:0] a_op;
    logic signed [W-1:0] res;
    logic                ovf;

    // Samples addressed to a channel that does not exist are dropped at the door
    assign in_ok = in_valid && ({1'b0, in_ch} < CH_LIM);

    // Stage 1: capture the sample and its control bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_vld  <= 1'b0;
            s1_ch   <= '0;
            s1_dat  <= '0;
            s1_clr  <= 1'b0;
            s1_last <= 1'b0;
            s1_sat  <= 1'b0;
        end else begin
            s1_vld  <= in_ok;
            s1_ch   <= in_ch;
            s1_dat  <= in_data;
            s1_clr  <= in_clr;
            s1_last <= in_last;
            s1_sat  <= sat_en;
        end
    end

    // Frame start restarts from zero; otherwise read the channel's running sum
    always_comb begin
        a_op = '0;
        if (!s1_clr) begin
            a_op = acc[s1_ch];
        end
    end

    sumador_sat_sim #(.W(W)) u_sumador (
        .a      (a_op),
        .b      (s1_dat),
        .sat_en (s1_sat),
        .result (res),
        .ovf    (ovf)
    );

    // Stage 2: write back the new sum; the next cycle's read sees it directly, so no bypass is needed
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                acc[i] <= '0;
            end
        end else if (s1_vld) begin
            acc[s1_ch] <= res;
        end
    end

    // Sticky overflow flags; a new overflow beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_flag <= '0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (s1_vld && ovf && (s1_ch == CHW'(c))) begin
                    ovf_flag[c] <= 1'b1;
                end else if (flag_clr[c]) begin
                    ovf_flag[c] <= 1'b0;
                end
            end
        end
    end

    // Result strobe on frame end; channel and data hold between strobes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= s1_vld && s1_last;
            if (s1_vld && s1_last) begin
                out_ch   <= s1_ch;
                out_data <= res;
            end
        end
    end

endmodule

// File: tb/tb_acumulador_sat.sv
// Directed testbench for acumulador_sat with hand-computed expectations.
// Inputs driven 1 time unit after the rising edge, outputs sampled at the same point.
// Summary line reports comparisons made and failures.
module tb_acumulador_sat;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic [1:0]         in_ch;
    logic signed [24:0] in_data;
    logic               in_clr;
    logic               in_last;
    logic               sat_en;
    logic [3:0]         flag_clr;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [24:0] out_data;
    logic [3:0]         ovf_flag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    acumulador_sat dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .in_clr    (in_clr),
        .in_last   (in_last),
        .sat_en    (sat_en),
        .flag_clr  (flag_clr),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .ovf_flag  (ovf_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one edge, then return the bus to idle
    task automatic send(input logic [1:0] ch, input logic signed [24:0] d,
                        input logic clr, input logic last, input logic sat);
        in_valid = 1'b1; in_ch = ch; in_data = d; in_clr = clr; in_last = last; sat_en = sat;
        tick();
        in_valid = 1'b0; in_clr = 1'b0; in_last = 1'b0; in_data = '0;
    endtask

    task automatic pulse_flag_clr(input logic [3:0] m);
        flag_clr = m;
        tick();
        flag_clr = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; in_clr = 1'b0;
        in_last = 1'b0; sat_en = 1'b0; flag_clr = '0;
        tick(); tick();
        reset_n = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        checks++; if (out_data !== 25'sd0) begin errors++; $display("FAIL reset_data got %0d exp 0", out_data); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL reset_ch got %0d exp 0", out_ch); end
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", ovf_flag); end
    endtask

    task automatic test_basic_sum();
        send(2'd0, 25'sd100, 1'b1, 1'b0, 1'b1);
        send(2'd0, 25'sd200, 1'b0, 1'b0, 1'b1);
        send(2'd0, 25'sd300, 1'b0, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got %0b exp 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
        checks++; if (out_ch !== 2'd0) begin errors++; $display("FAIL basic_ch got %0d exp 0", out_ch); end
        checks++; if (out_data !== 25'sd600) begin errors++; $display("FAIL basic_data got %0d exp 600", out_data); end
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL basic_flags got %b exp 0000", ovf_flag); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_single got %0b exp 0", out_valid); end
        checks++; if (out_data !== 25'sd600) begin errors++; $display("FAIL basic_hold got %0d exp 600", out_data); end
        // Accumulator survives frame end: a last-only sample continues from 600
        send(2'd0, 25'sd1, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out_data !== 25'sd601) begin errors++; $display("FAIL keep_after_last got %0d exp 601", out_data); end
    endtask

    task automatic test_idle_ignored();
        in_valid = 1'b0; in_ch = 2'd0; in_data = 25'sd999; in_clr = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid[%0d] got %0b exp 0", i, out_valid); end
        end
        in_clr = 1'b0; in_last = 1'b0; in_data = '0;
        send(2'd0, 25'sd0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out_data !== 25'sd601) begin errors++; $display("FAIL idle_acc got %0d exp 601", out_data); end
    endtask

    task automatic test_sat_pos();
        send(2'd1, 25'sd16777000, 1'b1, 1'b0, 1'b1);
        send(2'd1, 25'sd500, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out_data !== 25'sd16777215) begin errors++; $display("FAIL sat_pos_data got %0d exp 16777215", out_data); end
        checks++; if (ovf_flag !== 4'b0010) begin errors++; $display("FAIL sat_pos_flag got %b exp 0010", ovf_flag); end
        pulse_flag_clr(4'b0010);
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL flag_clear got %b exp 0000", ovf_flag); end
    endtask

    task automatic test_wrap();
        send(2'd1, 25'sd16777000, 1'b1, 1'b0, 1'b0);
        send(2'd1, 25'sd500, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out_data !== -25'sd16776932) begin errors++; $display("FAIL wrap_data got %0d exp -16776932", out_data); end
        checks++; if (ovf_flag !== 4'b0010) begin errors++; $display("FAIL wrap_flag got %b exp 0010", ovf_flag); end
        pulse_flag_clr(4'b0010);
    endtask

    task automatic test_sat_neg();
        send(2'd2, -25'sd16777215, 1'b1, 1'b0, 1'b1);
        send(2'd2, -25'sd1, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out_data !== -25'sd16777215) begin errors++; $display("FAIL most_neg_data got %0d exp -16777215", out_data); end
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL most_neg_flag got %b exp 0000", ovf_flag); end
        send(2'd2, -25'sd16777215, 1'b1, 1'b0, 1'b1);
        send(2'd2, -25'sd10, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out_data !== -25'sd16777215) begin errors++; $display("FAIL sat_neg_data got %0d exp -16777215", out_data); end
        checks++; if (ovf_flag !== 4'b0100) begin errors++; $display("FAIL sat_neg_flag got %b exp 0100", ovf_flag); end
        pulse_flag_clr(4'b0100);
    endtask

    task automatic test_back_to_back();
        send(2'd0, 25'sd5, 1'b1, 1'b0, 1'b1);
        send(2'd3, 25'sd7, 1'b1, 1'b0, 1'b1);
        send(2'd0, 25'sd10, 1'b0, 1'b1, 1'b1);
        send(2'd3, -25'sd20, 1'b0, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 25'sd15) begin
            errors++; $display("FAIL b2b_first got v=%0b ch=%0d d=%0d exp v=1 ch=0 d=15", out_valid, out_ch, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== -25'sd13) begin
            errors++; $display("FAIL b2b_second got v=%0b ch=%0d d=%0d exp v=1 ch=3 d=-13", out_valid, out_ch, out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b exp 0", out_valid); end
    endtask

    task automatic test_set_beats_clear();
        send(2'd0, 25'sd16777000, 1'b1, 1'b0, 1'b1);
        send(2'd0, 25'sd500, 1'b0, 1'b1, 1'b1);
        // Overflowing sample is in stage 1 now; clear lands on the same edge as the set
        pulse_flag_clr(4'b0001);
        checks++; if (ovf_flag[0] !== 1'b1) begin errors++; $display("FAIL set_wins got %0b exp 1", ovf_flag[0]); end
        checks++; if (out_data !== 25'sd16777215) begin errors++; $display("FAIL set_wins_data got %0d exp 16777215", out_data); end
        pulse_flag_clr(4'b0001);
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL clear_after got %b exp 0000", ovf_flag); end
    endtask

    task automatic test_reset_in_flight();
        send(2'd3, 25'sd16777000, 1'b1, 1'b0, 1'b0);
        send(2'd3, 25'sd500, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (ovf_flag !== 4'b1000) begin errors++; $display("FAIL pre_reset_flag got %b exp 1000", ovf_flag); end
        send(2'd1, 25'sd7, 1'b1, 1'b1, 1'b1);
        send(2'd2, 25'sd9, 1'b1, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 25'sd7) begin
            errors++; $display("FAIL pre_reset_out got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=7", out_valid, out_ch, out_data); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++; if (out_valid !== 1'b0 || out_data !== 25'sd0 || out_ch !== 2'd0) begin
            errors++; $display("FAIL midreset_out got v=%0b ch=%0d d=%0d exp v=0 ch=0 d=0", out_valid, out_ch, out_data); end
        checks++; if (ovf_flag !== 4'b0000) begin errors++; $display("FAIL midreset_flags got %b exp 0000", ovf_flag); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_drain[%0d] got %0b exp 0", i, out_valid); end
        end
        send(2'd1, 25'sd4, 1'b0, 1'b1, 1'b1);
        send(2'd3, 25'sd4, 1'b0, 1'b1, 1'b1);
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 25'sd4) begin
            errors++; $display("FAIL acc1_zeroed got v=%0b ch=%0d d=%0d exp v=1 ch=1 d=4", out_valid, out_ch, out_data); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 25'sd4) begin
            errors++; $display("FAIL acc3_zeroed got v=%0b ch=%0d d=%0d exp v=1 ch=3 d=4", out_valid, out_ch, out_data); end
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_idle_ignored();
        test_sat_pos();
        test_wrap();
        test_sat_neg();
        test_back_to_back();
        test_set_beats_clear();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
